// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported RAM between instruction fetch and data access.
// Optional per-access wait timeout: define ARB_TIMEOUT_EN.
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MAX_DBURST = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dhit,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              arb_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] IACC = 2'd1;
    localparam logic [1:0] DACC = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [3:0] DBURST_MAX = 4'(MAX_DBURST);

    if (MAX_DBURST < 1 || MAX_DBURST > 15) begin : g_bad_max_dburst
        $error("mem_arbiter: MAX_DBURST must be within 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be within 1..255");
    end

    logic [1:0]        state_r,      state_s;
    logic [3:0]        dburst_cnt_r, dburst_cnt_s;
    logic              wr_r,         wr_s;
    logic              ihit_r,       ihit_s;
    logic              dhit_r,       dhit_s;
    logic [WORD_W-1:0] iload_r,      iload_s;
    logic [WORD_W-1:0] dload_r,      dload_s;
    logic              ramren_r,     ramren_s;
    logic              ramwen_r,     ramwen_s;
    logic [ADDR_W-1:0] ramaddr_r,    ramaddr_s;
    logic [WORD_W-1:0] ramstore_r,   ramstore_s;
    logic              arb_err_r,    arb_err_s;
    logic              d_req_s;
    logic              i_starved_s;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0]        wait_cnt_r,   wait_cnt_s;
`endif

    // Next-state, strobe, hit and capture logic for the access FSM
    always_comb begin
        state_s      = state_r;
        dburst_cnt_s = dburst_cnt_r;
        wr_s         = wr_r;
        ihit_s       = 1'b0;
        dhit_s       = 1'b0;
        iload_s      = iload_r;
        dload_s      = dload_r;
        ramren_s     = 1'b0;
        ramwen_s     = 1'b0;
        ramaddr_s    = ramaddr_r;
        ramstore_s   = ramstore_r;
        arb_err_s    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        wait_cnt_s   = wait_cnt_r;
`endif
        d_req_s      = dREN | dWEN;
        // Fetch is forced through once data has used its whole burst budget
        i_starved_s  = iREN && (dburst_cnt_r == DBURST_MAX);

        case (state_r)
            IDLE: begin
                if (d_req_s && !i_starved_s) begin
                    state_s    = DACC;
                    ramaddr_s  = daddr;
                    ramstore_s = dstore;
                    wr_s       = dWEN;
                    ramren_s   = ~dWEN;
                    ramwen_s   = dWEN;
                    if (dburst_cnt_r == DBURST_MAX) begin
                        dburst_cnt_s = dburst_cnt_r;
                    end else begin
                        dburst_cnt_s = dburst_cnt_r + 4'd1;
                    end
`ifdef ARB_TIMEOUT_EN
                    wait_cnt_s = 8'd0;
`endif
                end else if (iREN) begin
                    state_s      = IACC;
                    ramaddr_s    = iaddr;
                    wr_s         = 1'b0;
                    ramren_s     = 1'b1;
                    dburst_cnt_s = 4'd0;
`ifdef ARB_TIMEOUT_EN
                    wait_cnt_s = 8'd0;
`endif
                end else begin
                    dburst_cnt_s = 4'd0;
                end
            end
            IACC, DACC: begin
                if (ram_ready) begin
                    state_s = RESP;
                    ihit_s  = (state_r == IACC);
                    dhit_s  = (state_r == DACC);
                    if (state_r == IACC) begin
                        iload_s = ramload;
                    end else if (!wr_r) begin
                        dload_s = ramload;
                    end else begin
                        dload_s = dload_r;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_s   = IDLE;
                        arb_err_s = 1'b1;
                    end else begin
                        ramren_s   = ~wr_r;
                        ramwen_s   = wr_r;
                        wait_cnt_s = wait_cnt_r + 8'd1;
                    end
`else
                    ramren_s = ~wr_r;
                    ramwen_s = wr_r;
`endif
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            dburst_cnt_r <= 4'd0;
            wr_r         <= 1'b0;
            ihit_r       <= 1'b0;
            dhit_r       <= 1'b0;
            iload_r      <= '0;
            dload_r      <= '0;
            ramren_r     <= 1'b0;
            ramwen_r     <= 1'b0;
            ramaddr_r    <= '0;
            ramstore_r   <= '0;
            arb_err_r    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wait_cnt_r   <= 8'd0;
`endif
        end else begin
            state_r      <= state_s;
            dburst_cnt_r <= dburst_cnt_s;
            wr_r         <= wr_s;
            ihit_r       <= ihit_s;
            dhit_r       <= dhit_s;
            iload_r      <= iload_s;
            dload_r      <= dload_s;
            ramren_r     <= ramren_s;
            ramwen_r     <= ramwen_s;
            ramaddr_r    <= ramaddr_s;
            ramstore_r   <= ramstore_s;
            arb_err_r    <= arb_err_s;
`ifdef ARB_TIMEOUT_EN
            wait_cnt_r   <= wait_cnt_s;
`endif
        end
    end

    assign ihit     = ihit_r;
    assign dhit     = dhit_r;
    assign iload    = iload_r;
    assign dload    = dload_r;
    assign ramREN   = ramren_r;
    assign ramWEN   = ramwen_r;
    assign ramaddr  = ramaddr_r;
    assign ramstore = ramstore_r;
    assign arb_err  = arb_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MAX_DBURST=2; TIMEOUT=5 when ARB_TIMEOUT_EN).
`timescale 1ns/1ps

module tb_mem_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 5;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;
    logic        arb_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int ihit_seen;

    mem_arbiter #(
        .WORD_W    (32),
        .ADDR_W    (32),
        .MAX_DBURST(2),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .ihit     (ihit),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dhit     (dhit),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ram_ready(ram_ready),
        .arb_err  (arb_err)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // RAM completes the pending access with the given read data
    task automatic ram_ack(input logic [31:0] data);
        ram_ready = 1'b1;
        ramload   = data;
        tick();
        ram_ready = 1'b0;
        ramload   = 32'h0000_0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; iREN = 1'b1; iaddr = 32'h0000_0040;
        dREN = 1'b0; dWEN = 1'b0; daddr = 32'h0; dstore = 32'h0;
        ramload = 32'h0; ram_ready = 1'b0;

        // reset held two cycles with a pending fetch
        tick();
        tick();
        check_eq("rst_flags", 32'({ramREN, ramWEN, ihit, dhit, arb_err}), 32'h0);
        check_eq("rst_iload", iload, 32'h0);
        check_eq("rst_dload", dload, 32'h0);
        check_eq("rst_ramaddr", ramaddr, 32'h0);
        check_eq("rst_ramstore", ramstore, 32'h0);
        RST = 1'b0;
        check_eq("rst_release_idle", 32'(ramREN), 32'h0);

        // fetch only, RAM answers two cycles after the strobe appears
        tick();
        check_eq("fetch_ren", 32'(ramREN), 32'h1);
        check_eq("fetch_addr", ramaddr, 32'h0000_0040);
        tick();
        check_eq("fetch_wait1", 32'({ramREN, ramWEN, ihit}), 32'h4);
        tick();
        check_eq("fetch_wait2", 32'({ramREN, ramWEN, ihit}), 32'h4);
        ram_ack(32'h2008_0001);
        check_eq("fetch_hit", 32'({ihit, dhit, ramREN}), 32'h4);
        check_eq("fetch_iload", iload, 32'h2008_0001);
        iREN = 1'b0;
        ihit_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ihit) ihit_seen++;
        end
        check_eq("fetch_hit_once", 32'(ihit_seen), 32'h0);
        check_eq("fetch_iload_hold", iload, 32'h2008_0001);

        // simultaneous fetch and data write: data wins
        iREN = 1'b1; iaddr = 32'h0000_0080;
        dWEN = 1'b1; daddr = 32'h0000_0100; dstore = 32'hDEAD_BEEF;
        tick();
        check_eq("conf_strobes", 32'({ramREN, ramWEN}), 32'h1);
        check_eq("conf_waddr", ramaddr, 32'h0000_0100);
        check_eq("conf_wdata", ramstore, 32'hDEAD_BEEF);
        ram_ack(32'h1234_5678);
        check_eq("conf_dhit", 32'({ihit, dhit}), 32'h1);
        check_eq("conf_dload_wr", dload, 32'h0);
        dWEN = 1'b0;
        tick();
        check_eq("conf_idle", 32'({ramREN, ramWEN, ihit, dhit}), 32'h0);
        tick();
        check_eq("conf_iren", 32'({ramREN, ramWEN}), 32'h2);
        check_eq("conf_iaddr", ramaddr, 32'h0000_0080);
        ram_ack(32'hCAFE_F00D);
        check_eq("conf_ihit", 32'({ihit, dhit}), 32'h2);
        check_eq("conf_iload", iload, 32'hCAFE_F00D);
        iREN = 1'b0;
        tick();

        // both requests held: grant order D, D, I, D, D, I
        dREN = 1'b1; daddr = 32'h0000_0200;
        iREN = 1'b1; iaddr = 32'h0000_0300;
        for (int k = 0; k < 6; k++) begin
            logic        is_d;
            logic [31:0] data;
            is_d = ((k % 3) != 2);
            data = 32'hA000_0000 + 32'(k);
            tick();
            check_eq($sformatf("burst%0d_addr", k), ramaddr, is_d ? 32'h0000_0200 : 32'h0000_0300);
            check_eq($sformatf("burst%0d_ren", k), 32'({ramREN, ramWEN}), 32'h2);
            ram_ack(data);
            check_eq($sformatf("burst%0d_hit", k), 32'({ihit, dhit}), is_d ? 32'h1 : 32'h2);
            check_eq($sformatf("burst%0d_load", k), is_d ? dload : iload, data);
            tick();
        end
        dREN = 1'b0; iREN = 1'b0;
        tick();

        // reset during the second fetch-access cycle
        iREN = 1'b1; iaddr = 32'h0000_0044;
        tick();
        tick();
        check_eq("rstmid_ren", 32'(ramREN), 32'h1);
        RST = 1'b1;
        tick();
        check_eq("rstmid_drop", 32'({ramREN, ihit}), 32'h0);
        RST = 1'b0; iREN = 1'b0;
        tick();
        check_eq("rstmid_nohit", 32'({ramREN, ihit}), 32'h0);
        iREN = 1'b1; iaddr = 32'h0000_0048;
        tick();
        check_eq("rstmid_regrant", ramaddr, 32'h0000_0048);
        ram_ack(32'h0BAD_F00D);
        check_eq("rstmid_ihit", 32'(ihit), 32'h1);
        check_eq("rstmid_iload", iload, 32'h0BAD_F00D);
        iREN = 1'b0;
        tick();

        // data read request dropped mid-access still completes
        dREN = 1'b1; daddr = 32'h0000_0210;
        tick();
        dREN = 1'b0;
        tick();
        check_eq("drop_ren", 32'(ramREN), 32'h1);
        ram_ack(32'h1357_9BDF);
        check_eq("drop_dhit", 32'(dhit), 32'h1);
        check_eq("drop_dload", dload, 32'h1357_9BDF);
        tick();

        // dREN and dWEN together act as a write
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h0000_0104; dstore = 32'h0000_55AA;
        tick();
        check_eq("rw_strobes", 32'({ramREN, ramWEN}), 32'h1);
        check_eq("rw_wdata", ramstore, 32'h0000_55AA);
        ram_ack(32'hFFFF_FFFF);
        check_eq("rw_dhit", 32'(dhit), 32'h1);
        check_eq("rw_dload_hold", dload, 32'h1357_9BDF);
        dREN = 1'b0; dWEN = 1'b0;
        tick();

        // ram_ready while idle is ignored
        ram_ready = 1'b1; ramload = 32'hFFFF_0000;
        tick();
        check_eq("idle_ready_hits", 32'({ihit, dhit, ramREN, ramWEN}), 32'h0);
        tick();
        check_eq("idle_ready_iload", iload, 32'h0BAD_F00D);
        check_eq("idle_ready_dload", dload, 32'h1357_9BDF);
        ram_ready = 1'b0; ramload = 32'h0;

`ifdef ARB_TIMEOUT_EN
        // RAM never answers: abort after TIMEOUT wait cycles, then re-grant
        dREN = 1'b1; daddr = 32'h0000_0400;
        tick();
        check_eq("tmo_ren", 32'({ramREN, arb_err}), 32'h2);
        for (int i = 1; i < 5; i++) begin
            tick();
            check_eq($sformatf("tmo_wait%0d", i), 32'({ramREN, arb_err}), 32'h2);
        end
        tick();
        check_eq("tmo_err", 32'({ramREN, arb_err, dhit}), 32'h2);
        check_eq("tmo_dload", dload, 32'h1357_9BDF);
        tick();
        check_eq("tmo_regrant", 32'({ramREN, arb_err}), 32'h2);
        check_eq("tmo_regrant_addr", ramaddr, 32'h0000_0400);
        ram_ack(32'h600D_0001);
        check_eq("tmo_dhit", 32'(dhit), 32'h1);
        check_eq("tmo_dload_new", dload, 32'h600D_0001);
        dREN = 1'b0;
        tick();
`else
        check_eq("arb_err_tied", 32'(arb_err), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
